// File: rtl/alu_pkg.sv
// Shared opcode encodings and parameter checks for the pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpXor  = 3'b100,
        OpSlt  = 3'b101,
        OpSltu = 3'b110,
        OpRsvd = 3'b111
    } alu_op_e;

    localparam int unsigned SliceWidth = 4;

    function automatic bit width_legal(int unsigned w);
        return (w >= 8) && (w <= 64) && ((w % 8) == 0);
    endfunction

    // Opcodes that run the adder as A + ~B + 1.
    function automatic logic op_is_sub(alu_op_e op);
        return (op == OpSub) || (op == OpSlt) || (op == OpSltu);
    endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice; slices are rippled to build wider adders.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/pipe_alu.sv
// Two-stage valid/ready ALU: stage 1 adds the lower half, stage 2 the upper half plus flags.
module pipe_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       CTRL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZEROFLAG,
    output logic             NEGATIVEFLAG,
    output logic             CARRYFLAG,
    output logic             OVERFLOWFLAG,
    output logic             ILLEGAL
);

    localparam int unsigned Half   = WIDTH / 2;
    localparam int unsigned NSlice = Half / SliceWidth;

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("pipe_alu: WIDTH must be a multiple of 8 in 8..64");
    end

    // ---------------- Stage 1: lower half ----------------
    alu_op_e              op_in;
    logic                 sub_in;
    logic [Half-1:0]      b_lo_eff;
    logic [Half-1:0]      sum_lo;
    logic [NSlice:0]      c_lo;
    logic [Half-1:0]      lo_res;

    assign op_in    = alu_op_e'(CTRL);
    assign sub_in   = op_is_sub(op_in);
    assign b_lo_eff = sub_in ? ~B[Half-1:0] : B[Half-1:0];
    assign c_lo[0]  = sub_in;

    for (genvar i = 0; i < NSlice; i++) begin : g_lo
        cla u_cla (
            .a   (A[SliceWidth*i +: SliceWidth]),
            .b   (b_lo_eff[SliceWidth*i +: SliceWidth]),
            .cin (c_lo[i]),
            .sum (sum_lo[SliceWidth*i +: SliceWidth]),
            .cout(c_lo[i+1])
        );
    end

    always_comb begin
        lo_res = sum_lo;
        case (op_in)
            OpAnd:   lo_res = A[Half-1:0] & B[Half-1:0];
            OpOr:    lo_res = A[Half-1:0] | B[Half-1:0];
            OpXor:   lo_res = A[Half-1:0] ^ B[Half-1:0];
            default: lo_res = sum_lo;
        endcase
    end

    logic            s1_valid;
    alu_op_e         s1_op;
    logic [Half-1:0] s1_lo_res;
    logic            s1_carry;
    logic [Half-1:0] s1_a_hi;
    logic [Half-1:0] s1_b_hi;
    logic            s2_valid;
    logic            s2_adv;
    logic            in_fire;

    assign s2_adv   = !s2_valid || OUT_READY;
    assign IN_READY = !s1_valid || s2_adv;
    assign in_fire  = IN_VALID && IN_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_op     <= OpAdd;
            s1_lo_res <= '0;
            s1_carry  <= 1'b0;
            s1_a_hi   <= '0;
            s1_b_hi   <= '0;
        end else begin
            if (IN_READY) begin
                s1_valid <= IN_VALID;
            end
            if (in_fire) begin
                s1_op     <= op_in;
                s1_lo_res <= lo_res;
                s1_carry  <= c_lo[NSlice];
                s1_a_hi   <= A[WIDTH-1:Half];
                s1_b_hi   <= B[WIDTH-1:Half];
            end
        end
    end

    // ---------------- Stage 2: upper half and flags ----------------
    logic            sub_s1;
    logic [Half-1:0] b_hi_eff;
    logic [Half-1:0] sum_hi;
    logic [NSlice:0] c_hi;
    logic            add_ovf;

    assign sub_s1   = op_is_sub(s1_op);
    assign b_hi_eff = sub_s1 ? ~s1_b_hi : s1_b_hi;
    assign c_hi[0]  = s1_carry;

    for (genvar i = 0; i < NSlice; i++) begin : g_hi
        cla u_cla (
            .a   (s1_a_hi[SliceWidth*i +: SliceWidth]),
            .b   (b_hi_eff[SliceWidth*i +: SliceWidth]),
            .cin (c_hi[i]),
            .sum (sum_hi[SliceWidth*i +: SliceWidth]),
            .cout(c_hi[i+1])
        );
    end

    assign add_ovf = (s1_a_hi[Half-1] == b_hi_eff[Half-1]) && (sum_hi[Half-1] != s1_a_hi[Half-1]);

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic             ill_d;

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        ill_d   = 1'b0;
        case (s1_op)
            OpAdd, OpSub: begin
                res_d   = {sum_hi, s1_lo_res};
                carry_d = c_hi[NSlice];
                ovf_d   = add_ovf;
            end
            OpAnd:   res_d = {s1_a_hi & s1_b_hi, s1_lo_res};
            OpOr:    res_d = {s1_a_hi | s1_b_hi, s1_lo_res};
            OpXor:   res_d = {s1_a_hi ^ s1_b_hi, s1_lo_res};
            OpSlt:   res_d = {{(WIDTH-1){1'b0}}, sum_hi[Half-1] ^ add_ovf};
            OpSltu:  res_d = {{(WIDTH-1){1'b0}}, !c_hi[NSlice]};
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_valid     <= 1'b0;
            RESULT       <= '0;
            ZEROFLAG     <= 1'b0;
            NEGATIVEFLAG <= 1'b0;
            CARRYFLAG    <= 1'b0;
            OVERFLOWFLAG <= 1'b0;
            ILLEGAL      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            // Output registers only change when a new beat moves in, so a stall holds them.
            if (s1_valid) begin
                RESULT       <= res_d;
                ZEROFLAG     <= (res_d == '0);
                NEGATIVEFLAG <= res_d[WIDTH-1];
                CARRYFLAG    <= carry_d;
                OVERFLOWFLAG <= ovf_d;
                ILLEGAL      <= ill_d;
            end
        end
    end

    assign OUT_VALID = s2_valid;

endmodule

// File: tb/tb_pipe_alu.sv
// Directed bench for pipe_alu at WIDTH=32: vector table, stall/backpressure and reset sequences.
module tb_pipe_alu;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  CTRL = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] RESULT;
    logic        ZEROFLAG, NEGATIVEFLAG, CARRYFLAG, OVERFLOWFLAG, ILLEGAL;

    pipe_alu #(.WIDTH(32)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .A           (A),
        .B           (B),
        .CTRL        (CTRL),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .RESULT      (RESULT),
        .ZEROFLAG    (ZEROFLAG),
        .NEGATIVEFLAG(NEGATIVEFLAG),
        .CARRYFLAG   (CARRYFLAG),
        .OVERFLOWFLAG(OVERFLOWFLAG),
        .ILLEGAL     (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {ZEROFLAG, NEGATIVEFLAG, CARRYFLAG, OVERFLOWFLAG, ILLEGAL};
    endfunction

    // flg = {zero, negative, carry, overflow, illegal}
    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    initial begin
        int          k;
        int          in_idx;
        int          out_idx;
        logic [31:0] held;
        logic [4:0]  held_flg;
        logic [31:0] exp_q [8];
        logic [31:0] tmp_a;

        vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010};
        vecs[1]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10100};
        vecs[2]  = '{3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b01000};
        vecs[3]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000};
        vecs[4]  = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000};
        vecs[5]  = '{3'b111, 32'h00001234, 32'h00005678, 32'h00000000, 5'b10001};
        vecs[6]  = '{3'b000, 32'h0000FFFF, 32'h00000001, 32'h00010000, 5'b00000};
        vecs[7]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000};
        vecs[8]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000};
        vecs[9]  = '{3'b100, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 5'b01000};
        vecs[10] = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100};
        vecs[11] = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110};
        vecs[12] = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10000};
        vecs[13] = '{3'b101, 32'h80000000, 32'h00000001, 32'h00000001, 5'b00000};
        vecs[14] = '{3'b110, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'b00000};
        vecs[15] = '{3'b001, 32'h00010000, 32'h00000001, 32'h0000FFFF, 5'b00100};

        // Reset state
        #3;
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_result", 64'(RESULT), 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Table-driven single beats with latency check
        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            IN_VALID  = 1'b1;
            A         = vecs[i].a;
            B         = vecs[i].b;
            CTRL      = vecs[i].ctrl;
            OUT_READY = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), 64'(IN_READY), 64'd1);
            @(posedge CLK);
            k = 0;
            do begin
                @(negedge CLK);
                IN_VALID = 1'b0;
                k++;
            end while (!OUT_VALID && k < 8);
            check($sformatf("v%0d_latency", i), 64'(k), 64'd2);
            check($sformatf("v%0d_result", i), 64'(RESULT), 64'(vecs[i].res));
            check($sformatf("v%0d_flags", i), 64'(flags()), 64'(vecs[i].flg));
        end

        // Back-to-back 8 beats, OUT_READY low for cycles 3..6
        for (int i = 0; i < 8; i++) begin
            tmp_a = 32'h01010101 * i;
            exp_q[i] = (i % 2 == 0) ? tmp_a + 32'h10 : tmp_a ^ 32'h10;
        end
        in_idx  = 0;
        out_idx = 0;
        held    = '0;
        held_flg = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            OUT_READY = !(c >= 3 && c <= 6);
            if (in_idx < 8) begin
                IN_VALID = 1'b1;
                A        = 32'h01010101 * in_idx;
                B        = 32'h10;
                CTRL     = (in_idx % 2 == 0) ? 3'b000 : 3'b100;
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (c == 3) begin
                held     = RESULT;
                held_flg = flags();
            end
            if (c >= 3 && c <= 6) begin
                check($sformatf("stall%0d_in_ready", c), 64'(IN_READY), 64'd0);
                check($sformatf("stall%0d_out_valid", c), 64'(OUT_VALID), 64'd1);
                check($sformatf("stall%0d_hold", c), 64'(RESULT), 64'(held));
                check($sformatf("stall%0d_hold_flg", c), 64'(flags()), 64'(held_flg));
                check($sformatf("stall%0d_buffered", c), 64'(in_idx - out_idx), 64'd2);
            end
            if (OUT_VALID && OUT_READY) begin
                if (out_idx < 8) begin
                    check($sformatf("b2b_out%0d", out_idx), 64'(RESULT), 64'(exp_q[out_idx]));
                end else begin
                    check("b2b_extra_beat", 64'd1, 64'd0);
                end
                out_idx++;
            end
            if (IN_VALID && IN_READY) in_idx++;
        end
        check("b2b_count", 64'(out_idx), 64'd8);

        // Reset with two beats in flight
        @(negedge CLK);
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        A         = 32'h00000011;
        B         = 32'h00000022;
        CTRL      = 3'b000;
        @(negedge CLK);
        A = 32'h00000033;
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        check("pre_rst_out_valid", 64'(OUT_VALID), 64'd1);
        RST_N = 1'b0;
        #1;
        check("rst2_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst2_result", 64'(RESULT), 64'd0);
        check("rst2_flags", 64'(flags()), 64'd0);
        check("rst2_in_ready", 64'(IN_READY), 64'd1);
        @(negedge CLK);
        RST_N     = 1'b1;
        OUT_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            #1;
            check($sformatf("no_stale%0d", c), 64'(OUT_VALID), 64'd0);
        end
        @(negedge CLK);
        IN_VALID = 1'b1;
        A        = 32'h00000100;
        B        = 32'h00000001;
        CTRL     = 3'b001;
        @(posedge CLK);
        k = 0;
        do begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            k++;
        end while (!OUT_VALID && k < 8);
        check("post_rst_latency", 64'(k), 64'd2);
        check("post_rst_result", 64'(RESULT), 64'h000000FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values are multiples of 8 from 8 to 64.
REQ-002 Port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 Port IN_VALID  input  1  operand beat offered.
REQ-005 Port IN_READY  output  1  block accepts the beat this cycle.
REQ-006 Port A  input  WIDTH  operand A, two's complement.
REQ-007 Port B  input  WIDTH  operand B, two's complement.
REQ-008 Port CTRL  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT signed, 110 SLTU unsigned, 111 reserved.
REQ-009 Port OUT_VALID  output  1  result beat present.
REQ-010 Port OUT_READY  input  1  consumer accepts the result this cycle.
REQ-011 Port RESULT  output  WIDTH  operation result.
REQ-012 Port ZEROFLAG, NEGATIVEFLAG, CARRYFLAG, OVERFLOWFLAG, ILLEGAL  output  1 each  status of RESULT's operation.

Function
REQ-013 A beat SHALL transfer on the input when IN_VALID && IN_READY, and on the output when OUT_VALID && OUT_READY.
REQ-014 Pipeline SHALL have two register stages; latency SHALL be exactly 2 cycles from input transfer to OUT_VALID with no stall.
REQ-015 Stage 1 SHALL compute the lower WIDTH/2 bits of the add/sub result and the carry out of that half, and register them together with the upper operand halves, CTRL and valid.
REQ-016 Stage 2 SHALL compute the upper half using the registered mid carry, the full RESULT and all flags, and register them as the output stage.
REQ-017 SUB SHALL be computed as A + ~B + 1; ADD as A + B + 0.
REQ-018 CARRYFLAG SHALL equal the carry out of bit WIDTH-1 for ADD/SUB (SUB: 1 means no borrow), else 0.
REQ-019 OVERFLOWFLAG SHALL be the signed overflow for ADD/SUB, else 0.
REQ-020 SLT SHALL return 1 when (N xor V) of A-B is set, SLTU when the carry of A-B is 0; otherwise 0, zero-extended.
REQ-021 ZEROFLAG SHALL be 1 iff RESULT == 0; NEGATIVEFLAG SHALL equal RESULT[WIDTH-1].
REQ-022 CTRL 111 SHALL produce RESULT 0, ILLEGAL 1, ZEROFLAG 1, all other flags 0; ILLEGAL SHALL be 0 for every other opcode.
REQ-023 Each stage SHALL advance when it is empty or its downstream stage advances; IN_READY = !stage1_valid || stage1 advances (combinational path from OUT_READY permitted).
REQ-024 While OUT_VALID && !OUT_READY, RESULT and all flags SHALL hold stable, and at most two beats SHALL be buffered.
REQ-025 Simultaneous input and output transfer SHALL sustain one result per cycle with no bubble.
REQ-026 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.

Reset
REQ-027 Asserting RST_N low SHALL immediately clear both stage valid bits, so OUT_VALID = 0 and RESULT and all flags = 0.
REQ-028 In-flight beats SHALL be discarded on reset; the first accepted beat after release SHALL appear 2 cycles later.
REQ-029 IN_READY SHALL be 1 during and after reset.

Structure
REQ-030 Opcode encodings and the WIDTH legality check SHALL live in the shared package alu_pkg.
REQ-031 The adder SHALL be built from WIDTH/4 instances of the existing 4-bit carry-lookahead slice cla, rippled between slices; no other sub-module.

Verification (WIDTH = 32)
REQ-032 ADD 0x7FFFFFFF + 0x00000001 -> RESULT 0x80000000, NEG 1, OVF 1, CARRY 0, output 2 cycles after input.
REQ-033 SUB 5 - 5 -> RESULT 0, ZERO 1, CARRY 1; SUB 0 - 1 -> 0xFFFFFFFF, NEG 1, CARRY 0.
REQ-034 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; CTRL 111 -> RESULT 0, ILLEGAL 1.
REQ-035 Mid-carry case: ADD 0x0000FFFF + 1 -> 0x00010000, verifying carry propagation across the stage boundary.
REQ-036 Back-to-back 8 beats with OUT_READY held 0 for 4 cycles mid-stream -> IN_READY drops after 2 buffered beats, outputs stable, all 8 results in order.
REQ-037 RST_N low with 2 beats in flight -> OUT_VALID 0 immediately, no stale beat emitted after release.
